// File: rtl/palette_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : palette_access_ctrl
//  Description : Sequences CPU two-byte palette writes, video lookups and
//                default-palette reloads onto the shared palette RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_access_ctrl #(
    parameter int IDX_W  = 8,
    parameter int INIT_N = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PTR_WE,
    input  logic [IDX_W-1:0] PTR_DATA,
    input  logic             CPU_WE,
    input  logic [7:0]       CPU_DATA,
    input  logic             INIT_REQ,
    input  logic             VID_REQ,
    input  logic [IDX_W-1:0] VID_ADR,
    output logic [IDX_W-1:0] RAM_ADR,
    output logic             RAM_WE_RB,
    output logic             RAM_WE_G,
    output logic [7:0]       RAM_DBO_RB,
    output logic [7:0]       RAM_DBO_G,
    output logic             VID_VALID,
    output logic             BUSY,
    output logic [IDX_W-1:0] PTR
);

    localparam logic [0:0]       c_ST_IDLE   = 1'b0;
    localparam logic [0:0]       c_ST_INIT   = 1'b1;
    localparam logic [IDX_W-1:0] c_INIT_LAST = IDX_W'(INIT_N - 1);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_phase_second;
    logic [7:0]       r_rb_hold;
    logic [IDX_W-1:0] r_ptr;
    logic             r_pend;
    logic [IDX_W-1:0] r_pend_adr;
    logic [7:0]       r_pend_rb;
    logic [7:0]       r_pend_g;
    logic [IDX_W-1:0] r_adr_hold;
    logic             r_vid_valid;
    logic             r_busy;

    logic [IDX_W-1:0] w_adr;
    logic             w_we;
    logic [7:0]       w_rb;
    logic [7:0]       w_g;
    logic             w_commit;
    logic             w_init_wr;
    logic             w_capture;
    logic             w_pend_nxt;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] w_cnt_nxt;

    // Default palette: {R/B byte, G byte}; entries beyond 15 reload as black.
    function automatic logic [15:0] f_default(input logic [IDX_W-1:0] idx);
        logic [15:0] v;
        v = 16'h0000;
        if (int'(idx) < 16) begin
            case (idx[3:0])
                4'h0:    v = 16'h00_00;
                4'h1:    v = 16'h00_00;
                4'h2:    v = 16'h11_06;
                4'h3:    v = 16'h33_07;
                4'h4:    v = 16'h26_01;
                4'h5:    v = 16'h37_03;
                4'h6:    v = 16'h52_01;
                4'h7:    v = 16'h27_06;
                4'h8:    v = 16'h62_01;
                4'h9:    v = 16'h63_03;
                4'hA:    v = 16'h52_06;
                4'hB:    v = 16'h63_06;
                4'hC:    v = 16'h11_04;
                4'hD:    v = 16'h55_02;
                4'hE:    v = 16'h55_05;
                default: v = 16'h77_07;
            endcase
        end
        return v;
    endfunction

    // Video owns the port whenever it asks; reload and commits fill idle cycles.
    always_comb begin
        w_adr     = r_adr_hold;
        w_we      = 1'b0;
        w_rb      = 8'h00;
        w_g       = 8'h00;
        w_commit  = 1'b0;
        w_init_wr = 1'b0;
        if (RESET) begin
            w_adr = '0;
        end else if (VID_REQ) begin
            w_adr = VID_ADR;
        end else if (r_state == c_ST_INIT) begin
            w_adr       = r_cnt;
            w_we        = 1'b1;
            {w_rb, w_g} = f_default(r_cnt);
            w_init_wr   = 1'b1;
        end else if (r_pend) begin
            w_adr    = r_pend_adr;
            w_we     = 1'b1;
            w_rb     = r_pend_rb;
            w_g      = r_pend_g;
            w_commit = 1'b1;
        end
    end

    assign w_capture = CPU_WE & ~PTR_WE & r_phase_second & ~r_busy;

    always_comb begin
        w_pend_nxt  = r_pend;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_commit)  w_pend_nxt = 1'b0;
        if (w_capture) w_pend_nxt = 1'b1;
        if (INIT_REQ) begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = c_ST_INIT;
            w_cnt_nxt   = '0;
        end else if (w_init_wr) begin
            if (r_cnt == c_INIT_LAST) w_state_nxt = c_ST_IDLE;
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_phase_second <= 1'b0;
            r_rb_hold      <= 8'h00;
            r_ptr          <= '0;
            r_pend         <= 1'b0;
            r_pend_adr     <= '0;
            r_pend_rb      <= 8'h00;
            r_pend_g       <= 8'h00;
            r_adr_hold     <= '0;
            r_vid_valid    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_adr_hold  <= w_adr;
            r_vid_valid <= VID_REQ;
            r_busy      <= w_pend_nxt | (w_state_nxt == c_ST_INIT);

            if (PTR_WE) begin
                r_ptr          <= PTR_DATA;
                r_phase_second <= 1'b0;
            end else if (CPU_WE) begin
                if (!r_phase_second) begin
                    r_rb_hold      <= CPU_DATA;
                    r_phase_second <= 1'b1;
                end else begin
                    r_phase_second <= 1'b0;
                    if (!r_busy) begin
                        r_pend_adr <= r_ptr;
                        r_pend_rb  <= r_rb_hold;
                        r_pend_g   <= CPU_DATA & 8'h07;
                        r_ptr      <= r_ptr + 1'b1;
                    end
                end
            end
            // A reload request resynchronises the byte protocol.
            if (INIT_REQ) r_phase_second <= 1'b0;
        end
    end

    assign RAM_ADR    = w_adr;
    assign RAM_WE_RB  = w_we;
    assign RAM_WE_G   = w_we;
    assign RAM_DBO_RB = w_rb;
    assign RAM_DBO_G  = w_g;
    assign VID_VALID  = r_vid_valid;
    assign BUSY       = r_busy;
    assign PTR        = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_palette_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_access_ctrl
//  Description : Randomised and directed self-checking bench against a
//                behavioural palette access model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_access_ctrl;

    localparam int IDX_W  = 8;
    localparam int INIT_N = 16;

    logic             CLK;
    logic             RESET;
    logic             PTR_WE;
    logic [IDX_W-1:0] PTR_DATA;
    logic             CPU_WE;
    logic [7:0]       CPU_DATA;
    logic             INIT_REQ;
    logic             VID_REQ;
    logic [IDX_W-1:0] VID_ADR;
    logic [IDX_W-1:0] RAM_ADR;
    logic             RAM_WE_RB;
    logic             RAM_WE_G;
    logic [7:0]       RAM_DBO_RB;
    logic [7:0]       RAM_DBO_G;
    logic             VID_VALID;
    logic             BUSY;
    logic [IDX_W-1:0] PTR;

    palette_access_ctrl #(.IDX_W(IDX_W), .INIT_N(INIT_N)) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PTR_WE     (PTR_WE),
        .PTR_DATA   (PTR_DATA),
        .CPU_WE     (CPU_WE),
        .CPU_DATA   (CPU_DATA),
        .INIT_REQ   (INIT_REQ),
        .VID_REQ    (VID_REQ),
        .VID_ADR    (VID_ADR),
        .RAM_ADR    (RAM_ADR),
        .RAM_WE_RB  (RAM_WE_RB),
        .RAM_WE_G   (RAM_WE_G),
        .RAM_DBO_RB (RAM_DBO_RB),
        .RAM_DBO_G  (RAM_DBO_G),
        .VID_VALID  (VID_VALID),
        .BUSY       (BUSY),
        .PTR        (PTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_busy   = 0;

    logic [7:0] def_rb [16] = '{8'h00, 8'h00, 8'h11, 8'h33, 8'h26, 8'h37, 8'h52, 8'h27,
                                8'h62, 8'h63, 8'h52, 8'h63, 8'h11, 8'h55, 8'h55, 8'h77};
    logic [7:0] def_g  [16] = '{8'h00, 8'h00, 8'h06, 8'h07, 8'h01, 8'h03, 8'h01, 8'h06,
                                8'h01, 8'h03, 8'h06, 8'h06, 8'h04, 8'h02, 8'h05, 8'h07};

    // Observed RAM contents (from DUT writes) and model RAM contents
    logic [7:0] dut_rb [256];
    logic [7:0] dut_g  [256];
    logic [7:0] mdl_rb [256];
    logic [7:0] mdl_g  [256];

    // Behavioural model state
    logic       m_second;
    logic [7:0] m_hold;
    logic [7:0] m_ptr;
    logic       m_pend;
    logic [7:0] m_padr, m_prb, m_pg;
    logic       m_init;
    int         m_cnt;
    logic [7:0] m_adr_last;
    logic       m_vv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_second = 1'b0; m_hold = 8'h00; m_ptr = 8'h00; m_pend = 1'b0;
        m_padr = 8'h00; m_prb = 8'h00; m_pg = 8'h00; m_init = 1'b0; m_cnt = 0;
        m_adr_last = 8'h00; m_vv = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge against the model, advance model.
    task automatic step(input logic rst, input logic pwe, input logic [7:0] pd,
                        input logic cwe, input logic [7:0] cd, input logic ireq,
                        input logic vreq, input logic [7:0] vadr);
        logic [7:0] e_adr, e_rb, e_g;
        logic       e_we, busy_now, init_wr;
        RESET = rst; PTR_WE = pwe; PTR_DATA = pd; CPU_WE = cwe; CPU_DATA = cd;
        INIT_REQ = ireq; VID_REQ = vreq; VID_ADR = vadr;
        @(negedge CLK);
        e_adr = m_adr_last; e_we = 1'b0; e_rb = 8'h00; e_g = 8'h00;
        if (rst) e_adr = 8'h00;
        else if (vreq) e_adr = vadr;
        else if (m_init) begin
            e_adr = 8'(m_cnt); e_we = 1'b1;
            e_rb = (m_cnt < 16) ? def_rb[m_cnt] : 8'h00;
            e_g  = (m_cnt < 16) ? def_g[m_cnt]  : 8'h00;
        end else if (m_pend) begin
            e_adr = m_padr; e_we = 1'b1; e_rb = m_prb; e_g = m_pg;
        end
        check("RAM_ADR",   32'(RAM_ADR),   32'(e_adr));
        check("RAM_WE_RB", 32'(RAM_WE_RB), 32'(e_we));
        check("RAM_WE_G",  32'(RAM_WE_G),  32'(e_we));
        if (e_we) begin
            check("RAM_DBO_RB", 32'(RAM_DBO_RB), 32'(e_rb));
            check("RAM_DBO_G",  32'(RAM_DBO_G),  32'(e_g));
        end
        check("VID_VALID", 32'(VID_VALID), 32'(m_vv));
        check("BUSY",      32'(BUSY),      32'(m_pend | m_init));
        check("PTR",       32'(PTR),       32'(m_ptr));
        if (RAM_WE_RB) dut_rb[RAM_ADR] = RAM_DBO_RB;
        if (RAM_WE_G)  dut_g[RAM_ADR]  = RAM_DBO_G;
        if (RAM_WE_RB || RAM_WE_G) n_wr++;
        if (BUSY) n_busy++;

        if (rst) model_reset();
        else begin
            busy_now = m_pend | m_init;
            init_wr  = !vreq && m_init;
            if (e_we) begin mdl_rb[e_adr] = e_rb; mdl_g[e_adr] = e_g; end
            if (!vreq && !m_init && m_pend) m_pend = 1'b0;
            m_adr_last = e_adr;
            m_vv = vreq;
            if (pwe) begin
                m_ptr = pd; m_second = 1'b0;
            end else if (cwe) begin
                if (!m_second) begin
                    m_hold = cd; m_second = 1'b1;
                end else begin
                    m_second = 1'b0;
                    if (!busy_now) begin
                        m_pend = 1'b1; m_padr = m_ptr; m_prb = m_hold; m_pg = cd & 8'h07;
                        m_ptr = m_ptr + 8'd1;
                    end
                end
            end
            if (ireq) begin
                m_second = 1'b0; m_pend = 1'b0; m_init = 1'b1; m_cnt = 0;
            end else if (init_wr) begin
                if (m_cnt == INIT_N - 1) m_init = 1'b0;
                else m_cnt++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic cpu(input logic [7:0] d);
        step(0, 0, 8'h00, 1, d, 0, 0, 8'h00);
    endtask

    task automatic ptr_load(input logic [7:0] p);
        step(0, 1, p, 0, 8'h00, 0, 0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dut_rb[i] = 8'h00; dut_g[i] = 8'h00; mdl_rb[i] = 8'h00; mdl_g[i] = 8'h00;
        end
        RESET = 1'b1; PTR_WE = 0; PTR_DATA = 0; CPU_WE = 0; CPU_DATA = 0;
        INIT_REQ = 0; VID_REQ = 0; VID_ADR = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);

        // Basic pair
        ptr_load(8'h05); cpu(8'h72);
        n_busy = 0;
        cpu(8'h04); idle(3);
        check("basic_busy_cycles", 32'(n_busy), 32'd1);
        check("basic_ram_rb5", 32'(dut_rb[5]), 32'h72);
        check("basic_ram_g5",  32'(dut_g[5]),  32'h04);
        check("basic_ptr",     32'(PTR),       32'h06);

        // Video priority: commit deferred by three video cycles
        ptr_load(8'h05); cpu(8'h72); cpu(8'h04);
        n_wr = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h20);
        check("vid_no_write", 32'(n_wr), 32'd0);
        idle(1);
        check("vid_commit_after", 32'(n_wr), 32'd1);
        idle(2);

        // Pointer wrap and G upper-bit masking
        ptr_load(8'hFF); cpu(8'h11); cpu(8'hFF); idle(2);
        check("wrap_rb", 32'(dut_rb[255]), 32'h11);
        check("wrap_g",  32'(dut_g[255]),  32'h07);
        check("wrap_ptr", 32'(PTR), 32'h00);

        // Pointer resync
        n_wr = 0;
        cpu(8'h33);
        step(0, 1, 8'h02, 1, 8'h99, 0, 0, 8'h00);
        cpu(8'h44); cpu(8'h05); idle(3);
        check("resync_writes", 32'(n_wr), 32'd1);
        check("resync_rb2", 32'(dut_rb[2]), 32'h44);
        check("resync_g2",  32'(dut_g[2]),  32'h05);

        // Reload with alternating video and a dropped pair
        for (int i = 0; i < 16; i++) begin dut_rb[i] = 8'hEE; dut_g[i] = 8'hEE; end
        n_wr = 0;
        step(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
        for (int i = 0; i < 34; i++) begin
            logic c;
            c = (i == 5) || (i == 8);
            step(0, 0, 8'h00, c, (i == 5) ? 8'h12 : 8'h34, 0, i[0], 8'h80);
        end
        check("reload_writes", 32'(n_wr), 32'd16);
        check("reload_rb4", 32'(dut_rb[4]),  32'h26);
        check("reload_g4",  32'(dut_g[4]),   32'h01);
        check("reload_rbF", 32'(dut_rb[15]), 32'h77);
        check("reload_gF",  32'(dut_g[15]),  32'h07);
        check("reload_busy_end", 32'(BUSY), 32'd0);

        // Reset during reload at counter 7
        step(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
        idle(7);
        n_wr = 0;
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        idle(3);
        check("rst_init_writes", 32'(n_wr), 32'd0);
        // Reset with a commit pending
        ptr_load(8'h30); cpu(8'hAA); cpu(8'h03);
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        idle(2);
        check("rst_pend_writes", 32'(n_wr), 32'd0);
        check("rst_ptr", 32'(PTR), 32'h00);
        ptr_load(8'h31); cpu(8'h5A); cpu(8'h06); idle(2);
        check("post_rst_rb", 32'(dut_rb[8'h31]), 32'h5A);
        check("post_rst_g",  32'(dut_g[8'h31]),  32'h06);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, 8'($urandom),
                 $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 79) == 0,
                 $urandom_range(0, 2) == 0, 8'($urandom));
        end
        idle(40);
        for (int i = 0; i < 256; i++) begin
            check("ram_rb_final", 32'(dut_rb[i]), 32'(mdl_rb[i]));
            check("ram_g_final",  32'(dut_g[i]),  32'(mdl_g[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
